spu_dual_issue_ctrl: RTL

//  In-order dual-issue controller for the SPU-Lite issue stage. Holds one decoded instruction pair.

---
 rtl/spu_dual_issue_if.sv | 52 +++++
 rtl/spu_dual_issue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spu_dual_issue_if.sv
// Decode-to-issue and issue-to-pipe signal bundle for the SPU-Lite dual-issue controller.
// The master side is decode plus pipe sinks; the slave side is the issue controller.
interface spu_dual_issue_if #(
    parameter int REGW = 7,
    parameter int LATW = 4
);
    logic              in_valid;
    logic              in_ready;

    logic              ins0_valid;
    logic [31:0]       ins0_word;
    logic              ins0_pipe;
    logic              ins0_wr;
    logic [REGW-1:0]   ins0_dst;
    logic [3*REGW-1:0] ins0_src;
    logic [2:0]        ins0_src_use;
    logic [LATW-1:0]   ins0_lat;

    logic              ins1_valid;
    logic [31:0]       ins1_word;
    logic              ins1_pipe;
    logic              ins1_wr;
    logic [REGW-1:0]   ins1_dst;
    logic [3*REGW-1:0] ins1_src;
    logic [2:0]        ins1_src_use;
    logic [LATW-1:0]   ins1_lat;

    logic              even_valid;
    logic              even_slot;
    logic [31:0]       even_word;
    logic              odd_valid;
    logic              odd_slot;
    logic [31:0]       odd_word;

    modport master (
        output in_valid,
        output ins0_valid, ins0_word, ins0_pipe, ins0_wr, ins0_dst, ins0_src, ins0_src_use, ins0_lat,
        output ins1_valid, ins1_word, ins1_pipe, ins1_wr, ins1_dst, ins1_src, ins1_src_use, ins1_lat,
        input  in_ready,
        input  even_valid, even_slot, even_word,
        input  odd_valid, odd_slot, odd_word
    );

    modport slave (
        input  in_valid,
        input  ins0_valid, ins0_word, ins0_pipe, ins0_wr, ins0_dst, ins0_src, ins0_src_use, ins0_lat,
        input  ins1_valid, ins1_word, ins1_pipe, ins1_wr, ins1_dst, ins1_src, ins1_src_use, ins1_lat,
        output in_ready,
        output even_valid, even_slot, even_word,
        output odd_valid, odd_slot, odd_word
    );
endinterface

// File: rtl/spu_dual_issue_ctrl.sv
// In-order dual-issue controller: buffers one decoded pair, routes slots to the even/odd pipes,
// and stalls RAW/WAW hazards against a per-register latency scoreboard.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no instruction buffered
// ST_PAIR  | slot0 pending, slot1 pending if s1_vld_q
// ST_SLOT1 | slot0 already issued, only slot1 pending
module spu_dual_issue_ctrl #(
    parameter int NREGS = 128,
    parameter int LATW  = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    spu_dual_issue_if.slave    bus,
    output logic [31:0]        stall_cnt_o
);
    localparam int REGW = $clog2(NREGS);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PAIR  = 2'd1,
        ST_SLOT1 = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]       word;
        logic              pipe;
        logic              wr;
        logic [REGW-1:0]   dst;
        logic [3*REGW-1:0] src;
        logic [2:0]        src_use;
        logic [LATW-1:0]   lat;
    } slot_t;

    state_t          state_q;
    slot_t           s0_q;
    slot_t           s1_q;
    logic            s1_vld_q;
    logic [31:0]     stall_q;
    logic [LATW-1:0] cnt_q [NREGS];
    logic [LATW-1:0] cnt_d [NREGS];

    slot_t           ins0_in;
    slot_t           ins1_in;
    logic [NREGS-1:0] busy;
    logic            active;
    logic            rdy0;
    logic            rdy1;
    logic            pair_raw;
    logic            pair_waw;
    logic            iss0;
    logic            iss1;
    logic            in_ready;
    logic            accept;
    logic            stall_inc;

    logic            even_valid;
    logic            even_slot;
    logic [31:0]     even_word;
    logic            odd_valid;
    logic            odd_slot;
    logic [31:0]     odd_word;

    function automatic logic slot_ready(input slot_t s, input logic [NREGS-1:0] busy_v);
        logic rdy;
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (s.src_use[i] && busy_v[s.src[i*REGW +: REGW]]) begin
                rdy = 1'b0;
            end
        end
        if (s.wr && busy_v[s.dst]) begin
            rdy = 1'b0;
        end
        return rdy;
    endfunction

    // A latency of 0 behaves like 1: the result is usable the very next cycle.
    function automatic logic [LATW-1:0] lat_to_cnt(input logic [LATW-1:0] lat);
        return (lat == '0) ? '0 : lat - LATW'(1);
    endfunction

    assign ins0_in = {bus.ins0_word, bus.ins0_pipe, bus.ins0_wr, bus.ins0_dst,
                      bus.ins0_src, bus.ins0_src_use, bus.ins0_lat};
    assign ins1_in = {bus.ins1_word, bus.ins1_pipe, bus.ins1_wr, bus.ins1_dst,
                      bus.ins1_src, bus.ins1_src_use, bus.ins1_lat};

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    always_comb begin
        pair_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (s1_q.src_use[i] && s0_q.wr && (s1_q.src[i*REGW +: REGW] == s0_q.dst)) begin
                pair_raw = 1'b1;
            end
        end
    end

    assign pair_waw = s0_q.wr && s1_q.wr && (s0_q.dst == s1_q.dst);
    assign rdy0     = slot_ready(s0_q, busy);
    assign rdy1     = slot_ready(s1_q, busy);
    assign active   = !reset_i && !flush_i;

    assign iss0 = active && (state_q == ST_PAIR) && rdy0;
    assign iss1 = active && rdy1 &&
                  ((state_q == ST_SLOT1) ||
                   (iss0 && s1_vld_q && (s0_q.pipe != s1_q.pipe) && !pair_raw && !pair_waw));

    // Refill in the same cycle the buffer drains so back-to-back pairs see no bubble.
    assign in_ready = active &&
                      ((state_q == ST_EMPTY) ||
                       ((state_q == ST_PAIR) && iss0 && (iss1 || !s1_vld_q)) ||
                       ((state_q == ST_SLOT1) && iss1));
    assign accept    = bus.in_valid && in_ready;
    assign stall_inc = active && (state_q != ST_EMPTY) && !iss0 && !iss1;

    always_comb begin
        even_valid = 1'b0;
        even_slot  = 1'b0;
        even_word  = '0;
        odd_valid  = 1'b0;
        odd_slot   = 1'b0;
        odd_word   = '0;
        if (iss0) begin
            if (s0_q.pipe) begin
                odd_valid = 1'b1;
                odd_word  = s0_q.word;
            end else begin
                even_valid = 1'b1;
                even_word  = s0_q.word;
            end
        end
        if (iss1) begin
            if (s1_q.pipe) begin
                odd_valid = 1'b1;
                odd_slot  = 1'b1;
                odd_word  = s1_q.word;
            end else begin
                even_valid = 1'b1;
                even_slot  = 1'b1;
                even_word  = s1_q.word;
            end
        end
    end

    // Dual issue never writes the same dst twice, so the two overrides cannot collide.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : '0;
        end
        if (iss0 && s0_q.wr) begin
            cnt_d[s0_q.dst] = lat_to_cnt(s0_q.lat);
        end
        if (iss1 && s1_q.wr) begin
            cnt_d[s1_q.dst] = lat_to_cnt(s1_q.lat);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_EMPTY;
            s0_q     <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            stall_q  <= '0;
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (flush_i) begin
                state_q  <= ST_EMPTY;
                s1_vld_q <= 1'b0;
            end else if (accept) begin
                s0_q     <= ins0_in;
                s1_q     <= ins1_in;
                s1_vld_q <= bus.ins1_valid;
                if (bus.ins0_valid) begin
                    state_q <= ST_PAIR;
                end else if (bus.ins1_valid) begin
                    state_q <= ST_SLOT1;
                end else begin
                    state_q <= ST_EMPTY;
                end
            end else begin
                case (state_q)
                    ST_PAIR: begin
                        if (iss0) begin
                            state_q <= (iss1 || !s1_vld_q) ? ST_EMPTY : ST_SLOT1;
                        end
                    end
                    ST_SLOT1: begin
                        if (iss1) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.even_valid = even_valid;
    assign bus.even_slot  = even_slot;
    assign bus.even_word  = even_word;
    assign bus.odd_valid  = odd_valid;
    assign bus.odd_slot   = odd_slot;
    assign bus.odd_word   = odd_word;
    assign stall_cnt_o    = stall_q;
endmodule
